// File: rtl/elastic_delay_chain.sv
// Elastic register chain with per-stage valid bits, collapsing bubbles, synchronous flush and occupancy.
// Optional saturating stall counter output enabled by ELASTIC_DELAY_CHAIN_STALL_CNT_EN.
module elastic_delay_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_bus,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_bus,
  input  logic                           out_ready,
`ifdef ELASTIC_DELAY_CHAIN_STALL_CNT_EN
  output logic [31:0]                    stall_cnt,
`endif
  output logic [$clog2(STAGES+1)-1:0]    occupancy
);

  localparam int OW = $clog2(STAGES+1);

  if (STAGES < 1 || STAGES > 64) begin : g_bad_stages
    $fatal(1, "elastic_delay_chain: STAGES must be in 1..64");
  end

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] adv;
  logic              push;
  logic              pop;

  // adv[i] unrolled from its recursive form: a stage moves if any stage at or
  // above it is empty, or the output is being drained.
  always_comb begin
    adv = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[i] = out_ready;
      for (int unsigned j = i; j < STAGES; j++) begin
        if (!v[j]) adv[i] = 1'b1;
      end
    end
  end

  assign in_ready  = adv[0] && !flush;
  assign out_valid = v[STAGES-1];
  assign out_bus   = d[STAGES-1];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int unsigned i = 0; i < STAGES; i++) d[i] <= '0;
    end else if (flush) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        d[0] <= in_bus;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end

`ifdef ELASTIC_DELAY_CHAIN_STALL_CNT_EN
  // Survives flush on purpose: it measures downstream back-pressure over the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Stall counter not built.
`endif

endmodule
